// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS main control unit: state encoding,
// opcode values, datapath mux/ALU encodings and the per-state control word.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W_DEF = 6;
  localparam int unsigned ALUOP_W_DEF  = 2;
  localparam int unsigned CNT_W_DEF    = 32;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_e;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    srcb_e   alu_src_b;
    alu_op_e alu_op;
    pcsrc_e  pc_source;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing bundle of the main control unit: instruction/status inputs
// and the per-cycle control enables plus status outputs.
interface multicycle_ctrl_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegDst;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [1:0]          PCSource;
  logic                illegal_op;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, retired
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state (+mem_ready) to control-word decode; en=0 forces every
// enable low so nothing is asserted while the controller is held in reset.
module mc_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  input  logic       en,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    if (en) begin
      case (state)
        S_FETCH: begin
          cw.mem_read  = 1'b1;
          cw.alu_src_b = SRCB_FOUR;
          // IR and PC update only on the cycle the fetch completes
          cw.ir_write  = mem_ready;
          cw.pc_write  = mem_ready;
        end
        S_DECODE:  cw.alu_src_b = SRCB_IMM_SH;
        S_MEMADDR: begin
          cw.alu_src_a = 1'b1;
          cw.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          cw.mem_read = 1'b1;
          cw.iord     = 1'b1;
        end
        S_MEMWB: begin
          cw.reg_write  = 1'b1;
          cw.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          cw.mem_write = 1'b1;
          cw.iord      = 1'b1;
        end
        S_REXEC: begin
          cw.alu_src_a = 1'b1;
          cw.alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          cw.reg_write = 1'b1;
          cw.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          cw.alu_src_a     = 1'b1;
          cw.alu_op        = ALU_SUB;
          cw.pc_write_cond = 1'b1;
          cw.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          cw.pc_write  = 1'b1;
          cw.pc_source = PCSRC_JUMP;
        end
        S_IEXEC: begin
          cw.alu_src_a = 1'b1;
          cw.alu_src_b = SRCB_IMM;
        end
        S_IWB:   cw.reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with illegal-opcode trap and retire counter.
// Define CTRL_IMM_EN to decode ADDI (0x08) through IEXEC/IWB instead of trapping.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = OPCODE_W_DEF,
  parameter int unsigned ALUOP_W  = ALUOP_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  multicycle_ctrl_if.master  bus
);

  state_e           state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_word_t       cw_c;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .en        (rst_n),
    .cw        (cw_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_op_d = illegal_op_q;
    retired_d    = retired_q;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OPCODE_W'(OP_LW) || bus.opcode == OPCODE_W'(OP_SW))
          state_d = S_MEMADDR;
        else if (bus.opcode == OPCODE_W'(OP_R))
          state_d = S_REXEC;
        else if (bus.opcode == OPCODE_W'(OP_BEQ))
          state_d = S_BRANCH;
        else if (bus.opcode == OPCODE_W'(OP_J))
          state_d = S_JUMP;
`ifdef CTRL_IMM_EN
        else if (bus.opcode == OPCODE_W'(OP_ADDI))
          state_d = S_IEXEC;
`endif
        else
          state_d = S_TRAP;
      end
      S_MEMADDR: state_d = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_REXEC:   state_d = S_RWB;
      S_IEXEC:   state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:    illegal_op_d = 1'b1;
      default:   state_d = S_FETCH;
    endcase
    // Every return to FETCH from another state completes one instruction
    if (state_q != S_FETCH && state_d == S_FETCH)
      retired_d = retired_q + CNT_W'(1);
  end

  assign bus.PCWrite     = cw_c.pc_write;
  assign bus.PCWriteCond = cw_c.pc_write_cond;
  assign bus.IorD        = cw_c.iord;
  assign bus.MemRead     = cw_c.mem_read;
  assign bus.MemWrite    = cw_c.mem_write;
  assign bus.IRWrite     = cw_c.ir_write;
  assign bus.MemtoReg    = cw_c.mem_to_reg;
  assign bus.RegDst      = cw_c.reg_dst;
  assign bus.RegWrite    = cw_c.reg_write;
  assign bus.ALUSrcA     = cw_c.alu_src_a;
  assign bus.ALUSrcB     = cw_c.alu_src_b;
  assign bus.ALUOp       = ALUOP_W'(cw_c.alu_op);
  assign bus.PCSource    = cw_c.pc_source;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-cycle expected control
// words are queued when inputs are driven and compared mid-cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic        pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0]  srcb, aluop, pcsrc;
    logic        ill;
    logic [31:0] ret;
  } obs_t;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, RX = 6, RWB = 7;
  localparam int BR = 8, JP = 9, IX = 10, IWB = 11, TR = 12, RST = 13;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04;
  localparam logic [5:0] JMP = 6'h02, ADDI = 6'h08, BAD = 6'h3F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  obs_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_ill;
  logic [31:0] exp_ret;

  // Expected outputs for a given controller state, straight from the state table
  function automatic obs_t ctl(input int st, input logic rdy, input logic ill,
                               input logic [31:0] ret);
    obs_t o;
    o = '0;
    o.ill = ill;
    o.ret = ret;
    case (st)
      F:   begin o.mrd = 1'b1; o.srcb = 2'd1; o.irw = rdy; o.pcw = rdy; end
      D:   o.srcb = 2'd3;
      MA:  begin o.srca = 1'b1; o.srcb = 2'd2; end
      MR:  begin o.mrd = 1'b1; o.iord = 1'b1; end
      MWB: begin o.rw = 1'b1; o.m2r = 1'b1; end
      MW:  begin o.mwr = 1'b1; o.iord = 1'b1; end
      RX:  begin o.srca = 1'b1; o.aluop = 2'b10; end
      RWB: begin o.rw = 1'b1; o.rdst = 1'b1; end
      BR:  begin o.srca = 1'b1; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 2'd1; end
      JP:  begin o.pcw = 1'b1; o.pcsrc = 2'd2; end
      IX:  begin o.srca = 1'b1; o.srcb = 2'd2; end
      IWB: o.rw = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic cyc(input string tag, input int st, input logic [5:0] op,
                     input logic rdy, input logic z, input bit retire);
    obs_t exp, obs;
    logic pc_load;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.zero      = z;
    sb.push_back(ctl(st, rdy, exp_ill, exp_ret));
    @(negedge clk);
    exp = sb.pop_front();
    obs = '{pcw: bus.PCWrite, pcwc: bus.PCWriteCond, iord: bus.IorD,
            mrd: bus.MemRead, mwr: bus.MemWrite, irw: bus.IRWrite,
            m2r: bus.MemtoReg, rdst: bus.RegDst, rw: bus.RegWrite,
            srca: bus.ALUSrcA, srcb: bus.ALUSrcB, aluop: bus.ALUOp,
            pcsrc: bus.PCSource, ill: bus.illegal_op, ret: bus.retired};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    if (st == BR) begin
      pc_load = bus.PCWrite | (bus.PCWriteCond & bus.zero);
      checks++;
      assert (pc_load === z) else begin
        errors++;
        $error("FAIL %s_pcload: observed=%b expected=%b", tag, pc_load, z);
      end
    end
    @(posedge clk);
    #1;
    if (retire) exp_ret = exp_ret + 32'd1;
    if (st == TR) exp_ill = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    exp_ill = 1'b0;
    exp_ret = 32'd0;
    cyc(tag, RST, LW, 1'b1, 1'b0, 1'b0);
    cyc(tag, RST, LW, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // LW, no stalls: 5 cycles
    cyc("lw_fetch",   F,   LW, 1'b1, 1'b0, 1'b0);
    cyc("lw_decode",  D,   LW, 1'b1, 1'b0, 1'b0);
    cyc("lw_memaddr", MA,  LW, 1'b1, 1'b0, 1'b0);
    cyc("lw_memrd",   MR,  LW, 1'b1, 1'b0, 1'b0);
    cyc("lw_memwb",   MWB, LW, 1'b1, 1'b0, 1'b1);

    // SW with a 3-cycle memory stall
    cyc("sw_fetch",   F,  SW, 1'b1, 1'b0, 1'b0);
    cyc("sw_decode",  D,  SW, 1'b0, 1'b0, 1'b0);
    cyc("sw_memaddr", MA, SW, 1'b0, 1'b0, 1'b0);
    cyc("sw_stall0",  MW, SW, 1'b0, 1'b0, 1'b0);
    cyc("sw_stall1",  MW, SW, 1'b0, 1'b0, 1'b0);
    cyc("sw_stall2",  MW, SW, 1'b0, 1'b0, 1'b0);
    cyc("sw_memwr",   MW, SW, 1'b1, 1'b0, 1'b1);

    // R-type with a 2-cycle fetch stall
    cyc("r_fstall0", F,   RT, 1'b0, 1'b0, 1'b0);
    cyc("r_fstall1", F,   RT, 1'b0, 1'b0, 1'b0);
    cyc("r_fetch",   F,   RT, 1'b1, 1'b0, 1'b0);
    cyc("r_decode",  D,   RT, 1'b1, 1'b0, 1'b0);
    cyc("r_exec",    RX,  RT, 1'b0, 1'b0, 1'b0);
    cyc("r_wb",      RWB, RT, 1'b1, 1'b0, 1'b1);

    // BEQ taken and not taken
    cyc("beq1_fetch",  F,  BEQ, 1'b1, 1'b1, 1'b0);
    cyc("beq1_decode", D,  BEQ, 1'b1, 1'b1, 1'b0);
    cyc("beq1_branch", BR, BEQ, 1'b1, 1'b1, 1'b1);
    cyc("beq0_fetch",  F,  BEQ, 1'b1, 1'b0, 1'b0);
    cyc("beq0_decode", D,  BEQ, 1'b1, 1'b0, 1'b0);
    cyc("beq0_branch", BR, BEQ, 1'b0, 1'b0, 1'b1);

    // J: mem_ready low in DECODE is ignored
    cyc("j_fetch",  F,  JMP, 1'b1, 1'b0, 1'b0);
    cyc("j_decode", D,  JMP, 1'b0, 1'b0, 1'b0);
    cyc("j_jump",   JP, JMP, 1'b0, 1'b0, 1'b1);

    // LW with a read stall in MEMRD
    cyc("lw2_fetch",   F,   LW, 1'b1, 1'b0, 1'b0);
    cyc("lw2_decode",  D,   LW, 1'b1, 1'b0, 1'b0);
    cyc("lw2_memaddr", MA,  LW, 1'b1, 1'b0, 1'b0);
    cyc("lw2_rstall",  MR,  LW, 1'b0, 1'b0, 1'b0);
    cyc("lw2_memrd",   MR,  LW, 1'b1, 1'b0, 1'b0);
    cyc("lw2_memwb",   MWB, LW, 1'b1, 1'b0, 1'b1);

    // ADDI: immediate path or trap depending on build
    cyc("addi_fetch",  F, ADDI, 1'b1, 1'b0, 1'b0);
    cyc("addi_decode", D, ADDI, 1'b1, 1'b0, 1'b0);
`ifdef CTRL_IMM_EN
    cyc("addi_iexec", IX,  ADDI, 1'b1, 1'b0, 1'b0);
    cyc("addi_iwb",   IWB, ADDI, 1'b1, 1'b0, 1'b1);
    cyc("addi_next",  F,   ADDI, 1'b0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 3; i++) cyc("addi_trap", TR, ADDI, 1'b1, 1'b0, 1'b0);
    do_reset("addi_reset");
`endif

    // Illegal opcode: absorbing trap until reset
    cyc("bad_fetch",  F, BAD, 1'b1, 1'b0, 1'b0);
    cyc("bad_decode", D, BAD, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("bad_trap", TR, BAD, 1'b1, 1'b0, 1'b0);
    do_reset("trap_reset");
    cyc("post_trap_fetch", F, LW, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a load
    cyc("mid_decode",  D,  LW, 1'b1, 1'b0, 1'b0);
    cyc("mid_memaddr", MA, LW, 1'b1, 1'b0, 1'b0);
    do_reset("mid_reset");
    cyc("mid_fetch",   F, SW, 1'b1, 1'b0, 1'b0);
    cyc("mid_decode2", D, SW, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
